// File: rtl/tt_um_fir_filter.sv
// Eight-tap direct-form FIR Tiny Tapeout tile: 8-bit unsigned samples, runtime-loadable coefficients.
// Optional macro FIR_SATURATE_EN clamps the scaled output to 0xFF instead of letting it wrap.
module tt_um_fir_filter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int TAPS = 8;

    logic [7:0]  x_q [TAPS];
    logic [7:0]  x_d [TAPS];
    logic [7:0]  c_q [TAPS];
    logic [7:0]  c_d [TAPS];
    logic [7:0]  y_q;
    logic [7:0]  y_d;
    logic [7:0]  x_sh [TAPS];
    logic [19:0] acc;
    logic [7:0]  y_red;
    logic        load;
    logic [2:0]  idx;
    logic        unused_bits;

    assign load        = uio_in[7];
    assign idx         = uio_in[2:0];
    assign unused_bits = ^{uio_in[6:3], acc[7:0], acc[19:16]};

    function automatic logic [15:0] tap_product(input logic [7:0] xv, input logic [7:0] cv);
        return {8'd0, xv} * {8'd0, cv};
    endfunction

`ifdef FIR_SATURATE_EN
    function automatic logic [7:0] reduce_out(input logic [11:0] y);
        return (y > 12'd255) ? 8'hFF : y[7:0];
    endfunction
    assign y_red = reduce_out(acc[19:8]);
`else
    function automatic logic [7:0] reduce_out(input logic [7:0] y);
        return y;
    endfunction
    assign y_red = reduce_out(acc[15:8]);
`endif

    // Stage 0: shifted delay line and exact 20-bit sum of products
    always_comb begin
        x_sh[0] = ui_in;
        for (int i = 1; i < TAPS; i++) begin
            x_sh[i] = x_q[i-1];
        end
        acc = '0;
        for (int i = 0; i < TAPS; i++) begin
            acc = acc + {4'd0, tap_product(x_sh[i], c_q[i])};
        end
    end

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            x_d[i] = x_q[i];
            c_d[i] = c_q[i];
        end
        y_d = y_q;
        if (ena) begin
            if (load) begin
                c_d[idx] = ui_in;
            end else begin
                for (int i = 0; i < TAPS; i++) begin
                    x_d[i] = x_sh[i];
                end
                y_d = y_red;
            end
        end
    end

    // Stage 1: delay line, coefficient bank and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= 8'h00;
                c_q[i] <= 8'h20;
            end
            y_q <= 8'h00;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= x_d[i];
                c_q[i] <= c_d[i];
            end
            y_q <= y_d;
        end
    end

    assign uo_out  = y_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_fir_filter.sv
// Scoreboard bench for tt_um_fir_filter: expected outputs queued at drive time, compared after each edge.
module tb_tt_um_fir_filter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_x [8];
    logic [7:0] m_c [8];
    logic [7:0] m_y;
    logic [7:0] sb_q [$];

    tt_um_fir_filter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model_y();
        int unsigned a;
        int unsigned y;
        a = 0;
        for (int i = 0; i < 8; i++) a += int'(m_x[i]) * int'(m_c[i]);
        y = a / 256;
`ifdef FIR_SATURATE_EN
        if (y > 255) return 8'hFF;
`endif
        return y[7:0];
    endfunction

    // exp_c >= 0 forces a fixed expected value; otherwise the model's output is queued
    task automatic drive(input string tag, input logic r, input logic e,
                         input logic [7:0] ui, input logic [7:0] uio, input int exp_c);
        logic [7:0] ev;
        rst_n  = r;
        ena    = e;
        ui_in  = ui;
        uio_in = uio;
        if (!r) begin
            for (int i = 0; i < 8; i++) begin
                m_x[i] = 8'h00;
                m_c[i] = 8'h20;
            end
            m_y = 8'h00;
        end else if (e) begin
            if (uio[7]) begin
                m_c[uio[2:0]] = ui;
            end else begin
                for (int i = 7; i > 0; i--) m_x[i] = m_x[i-1];
                m_x[0] = ui;
                m_y = model_y();
            end
        end
        ev = (exp_c >= 0) ? exp_c[7:0] : m_y;
        sb_q.push_back(ev);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            check_eq(tag, uo_out, sb_q.pop_front());
        end
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'hAA; uio_in = 8'h00;

        drive("reset0", 1'b0, 1'b1, 8'hAA, 8'h00, 0);
        drive("reset1", 1'b0, 1'b1, 8'hAA, 8'h00, 0);
        check_eq("uio_out", uio_out, 8'h00);
        check_eq("uio_oe", uio_oe, 8'h00);

        for (int k = 1; k <= 12; k++)
            drive("step", 1'b1, 1'b1, 8'h80, 8'h00, (k < 8 ? k : 8) * 16);

        for (int k = 0; k < 8; k++) drive("flush", 1'b1, 1'b1, 8'h00, 8'h00, -1);
        drive("impulse", 1'b1, 1'b1, 8'hFF, 8'h00, 31);
        for (int k = 1; k < 10; k++)
            drive("impulse", 1'b1, 1'b1, 8'h00, 8'h00, (k < 8) ? 31 : 0);

        drive("load_c0", 1'b1, 1'b1, 8'hFF, 8'h80, 0);
        for (int i = 1; i < 8; i++) drive("load_cz", 1'b1, 1'b1, 8'h00, 8'h80 | 8'(i), 0);
        for (int k = 0; k < 8; k++) drive("c0_only", 1'b1, 1'b1, 8'hFF, 8'h00, 254);

        drive("dup_load", 1'b1, 1'b1, 8'h10, 8'h83, -1);
        drive("dup_load", 1'b1, 1'b1, 8'h40, 8'hFB, -1);
        for (int k = 0; k < 8; k++) drive("dup_run", 1'b1, 1'b1, 8'(8'h11 * k), 8'h78, -1);

        for (int i = 0; i < 8; i++) drive("load_ff", 1'b1, 1'b1, 8'hFF, 8'h80 | 8'(i), -1);
        for (int k = 0; k < 7; k++) drive("ovf", 1'b1, 1'b1, 8'hFF, 8'h00, -1);
`ifdef FIR_SATURATE_EN
        drive("ovf_final", 1'b1, 1'b1, 8'hFF, 8'h00, 8'hFF);
`else
        drive("ovf_final", 1'b1, 1'b1, 8'hFF, 8'h00, 8'hF0);
`endif

        drive("mid_reset", 1'b0, 1'b1, 8'h55, 8'h80, 0);
        for (int k = 1; k <= 3; k++) drive("step2", 1'b1, 1'b1, 8'h80, 8'h00, k * 16);
        for (int k = 0; k < 5; k++) drive("ena_hold", 1'b1, 1'b0, 8'(8'h13 * k + 1), 8'h00, 48);
        drive("ena_hold", 1'b1, 1'b0, 8'hEE, 8'h85, 48);
        drive("resume", 1'b1, 1'b1, 8'h80, 8'h00, 64);
        drive("resume", 1'b1, 1'b1, 8'h80, 8'h00, 80);

        for (int k = 0; k < 60; k++) begin
            logic [7:0] ui;
            logic [7:0] uio;
            logic       e;
            ui  = 8'($urandom_range(0, 255));
            uio = ($urandom_range(0, 3) == 0) ? (8'h80 | 8'($urandom_range(0, 127))) : 8'($urandom_range(0, 127));
            e   = ($urandom_range(0, 5) != 0);
            drive("random", 1'b1, e, ui, uio, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
